// File: rtl/fb_scanout_if.sv
// fb_scanout_if: frame-buffer read port, swap handshake and VGA outputs of fb_scanout
interface fb_scanout_if;
  logic [18:0] read_addr;
  logic        read_data;
  logic        swap_request;
  logic        swap;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_pixel;
  logic        vga_de;
  logic        vblank;
  logic        frame_done;
  modport master (
    output read_addr, swap, vga_hsync, vga_vsync, vga_pixel, vga_de, vblank, frame_done,
    input  read_data, swap_request
  );
  modport slave (
    input  read_addr, swap, vga_hsync, vga_vsync, vga_pixel, vga_de, vblank, frame_done,
    output read_data, swap_request
  );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: VGA raster scan-out of a 1-bit frame buffer with tear-free swap; FB_SCANOUT_BORDER_EN adds an alignment border
module fb_scanout #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic          clk,
  input logic          rst,
  fb_scanout_if.master fb_io
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] D_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_B = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_B = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [DW-1:0] div_q;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [18:0]   addr_q, addr_d;
  logic          pend_q, hs_q, vs_q, pix_q, de_q, swap_q, fd_q;
  logic          pix_en, de, border, swap_eval, last_px;
  // next raster position, incremental address and per-pixel decode of the current position
  always_comb begin
    pix_en = div_q == D_MAX;
    h_d = h_q == H_LAST ? '0 : h_q + 10'd1;
    v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + 10'd1;
    addr_d = (h_d == '0 && v_d == '0) ? '0 : (h_d < HA && v_d < VA) ? addr_q + 19'd1 : addr_q;
    de = h_q < HA && v_q < VA;
`ifdef FB_SCANOUT_BORDER_EN
    border = h_q == '0 || h_q == HA - 10'd1 || v_q == '0 || v_q == VA - 10'd1;
`else
    border = 1'b0;
`endif
    swap_eval = pix_en && h_q == H_LAST && v_q == VA - 10'd1;
    last_px = pix_en && h_q == HA - 10'd1 && v_q == VA - 10'd1;
  end
  // pixel divider, raster counters, swap bookkeeping and one-pixel-latency output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      pend_q <= 1'b0;
      swap_q <= 1'b0;
      fd_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      pix_q  <= 1'b0;
    end else begin
      div_q  <= pix_en ? '0 : div_q + 1'b1;
      swap_q <= swap_eval && (pend_q || fb_io.swap_request);
      pend_q <= !swap_eval && (pend_q || fb_io.swap_request);
      fd_q   <= last_px;
      if (pix_en) begin
        h_q    <= h_d;
        v_q    <= v_d;
        addr_q <= addr_d;
        hs_q   <= !(h_q >= HS_B && h_q <= HS_E);
        vs_q   <= !(v_q >= VS_B && v_q <= VS_E);
        de_q   <= de;
        pix_q  <= de && (border || fb_io.read_data);
      end
    end
  end
  assign fb_io.read_addr  = addr_q;
  assign fb_io.swap       = swap_q;
  assign fb_io.vga_hsync  = hs_q;
  assign fb_io.vga_vsync  = vs_q;
  assign fb_io.vga_pixel  = pix_q;
  assign fb_io.vga_de     = de_q;
  assign fb_io.vblank     = v_q >= VA;
  assign fb_io.frame_done = fd_q;
endmodule
